// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path.
// Holds the active-low hex segment codes, ordered {g,f,e,d,c,b,a}.
// SEG_BLANK is the all-dark cathode pattern.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seven_seg_decoder.sv
// Purpose: hex nibble to active-low seven-segment cathode pattern.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of hex_i.
// Ports: hex_i (4-bit value), seg_o (cathodes {g,f,e,d,c,b,a}, active-low).
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Purpose: time-multiplexed common-anode scanner with hex decode, dp, blanking, PWM dimming, ghosting guard.
// Latency: all outputs registered, one clock behind the internal scan state.
// Backpressure: none; inputs are snapshotted once per frame, frame_tick marks each snapshot point.
// Ports: clk_10Mhz, reset_n (sync, active-low); digits/dp_in/blank/brightness/hold in;
//        an/seg/dp (active-low) and frame_tick out.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_COUNT   = 5000,
  parameter int GUARD_CYCLES = 16,
  parameter int PWM_BITS     = 3
) (
  input  logic                    clk_10Mhz,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    hold,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int SLOT_W = $clog2(SCAN_COUNT);
  localparam int PTR_W  = $clog2(NUM_DIGITS);

  localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(SCAN_COUNT - 1);
  localparam logic [SLOT_W-1:0]   GUARD     = SLOT_W'(GUARD_CYCLES);
  localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(NUM_DIGITS - 1);
  // PWM period is 2^PWM_BITS-1 so that all-ones brightness is permanently on.
  localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);

  // Scan state
  logic                    started_q;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PWM_BITS-1:0]     pwm_q, pwm_d;

  // Frame-synchronous input shadows
  logic [4*NUM_DIGITS-1:0] digit_sh_q;
  logic [NUM_DIGITS-1:0]   dp_sh_q;
  logic [NUM_DIGITS-1:0]   blank_sh_q;
  logic [PWM_BITS-1:0]     bright_sh_q;

  // Output registers
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    snap_en;
  logic                    lit;
  logic [3:0]              cur_hex;
  logic [6:0]              cur_seg;

  // Counter / pointer next state. The first clock out of reset only takes the
  // snapshot and leaves slot 0 of digit 0 starting on that edge.
  always_comb begin
    slot_d       = slot_q;
    ptr_d        = ptr_q;
    snap_en      = 1'b0;
    frame_tick_d = 1'b0;
    pwm_d        = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
    if (!started_q) begin
      snap_en = 1'b1;
    end else if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      if (ptr_q == PTR_LAST) begin
        ptr_d        = '0;
        frame_tick_d = 1'b1;
        snap_en      = !hold;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end else begin
      slot_d = slot_q + 1'b1;
    end
  end

  assign cur_hex = digit_sh_q[{ptr_q, 2'b00} +: 4];

  seven_seg_decoder u_dec (
    .hex_i (cur_hex),
    .seg_o (cur_seg)
  );

  // A digit is driven only outside the guard window, when not blanked and
  // while the PWM phase is on; otherwise anodes and cathodes all go dark.
  assign lit = (slot_q >= GUARD) && !blank_sh_q[ptr_q] && (pwm_q < bright_sh_q);

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~(NUM_DIGITS'(1) << ptr_q);
      seg_d = cur_seg;
      dp_d  = ~dp_sh_q[ptr_q];
    end
  end

  always_ff @(posedge clk_10Mhz) begin
    if (!reset_n) begin
      started_q    <= 1'b0;
      slot_q       <= '0;
      ptr_q        <= '0;
      pwm_q        <= '0;
      digit_sh_q   <= '0;
      dp_sh_q      <= '0;
      blank_sh_q   <= '1;
      bright_sh_q  <= '0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      started_q    <= 1'b1;
      slot_q       <= slot_d;
      ptr_q        <= ptr_d;
      pwm_q        <= pwm_d;
      if (snap_en) begin
        digit_sh_q  <= digits;
        dp_sh_q     <= dp_in;
        blank_sh_q  <= blank;
        bright_sh_q <= brightness;
      end
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with 4 digits, 8-clock slots, 2-clock guard, 3-bit PWM.
// Frame-relative timing: sample k after a frame_tick sample reflects slot k%8 of digit k/8.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int GC = 2;
  localparam int PB = 3;
  localparam int FRAME = ND * SC;

  logic          clk;
  logic          reset_n;
  logic [15:0]   digits;
  logic [3:0]    dp_in;
  logic [3:0]    blank;
  logic [2:0]    brightness;
  logic          hold;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_tick;

  seven_seg_scan #(
    .NUM_DIGITS   (ND),
    .SCAN_COUNT   (SC),
    .GUARD_CYCLES (GC),
    .PWM_BITS     (PB)
  ) dut (
    .clk_10Mhz  (clk),
    .reset_n    (reset_n),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank      (blank),
    .brightness (brightness),
    .hold       (hold),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  // Observation state
  logic [6:0] exp_seg [ND];
  int  lit_cnt [ND];
  int  dpl_cnt [ND];
  int  bad;
  int  ft_cnt;
  int  pos;
  bit  synced;
  bit  last_ft;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [2:0]  bright;
    logic [27:0] seg_codes;  // {d3,d2,d1,d0}
    logic [31:0] lit;        // per-digit lit cycles over 7 frames, bytes {d3,d2,d1,d0}
    logic [31:0] dpl;        // per-digit dp-low cycles over 7 frames
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < ND; i++) begin
      lit_cnt[i] = 0;
      dpl_cnt[i] = 0;
    end
    bad    = 0;
    ft_cnt = 0;
  endtask

  task automatic set_exp(input logic [27:0] codes);
    for (int i = 0; i < ND; i++) exp_seg[i] = codes[7*i +: 7];
  endtask

  // One cycle of observation: classify the outputs and flag anything illegal.
  task automatic sample();
    int k;
    int idx;
    logic [3:0] onehot;
    @(negedge clk);
    k   = pos;
    idx = -1;
    for (int i = 0; i < ND; i++) begin
      onehot = 4'b0001 << i;
      if (an == ~onehot) idx = i;
    end
    if (an == 4'hF) begin
      if (seg !== 7'h7F || dp !== 1'b1) bad++;
    end else if (idx < 0) begin
      bad++;
    end else begin
      lit_cnt[idx]++;
      if (dp == 1'b0) dpl_cnt[idx]++;
      if (seg !== exp_seg[idx]) bad++;
      if (synced && ((k % SC) < GC || ((k / SC) % ND) != idx)) bad++;
    end
    last_ft = frame_tick;
    if (frame_tick) begin
      ft_cnt++;
      if (synced && k != FRAME - 1) bad++;
      pos    = 0;
      synced = 1'b1;
    end else begin
      pos++;
      if (synced && pos >= FRAME) bad++;
    end
  endtask

  task automatic run_samples(input int n);
    for (int i = 0; i < n; i++) sample();
  endtask

  task automatic run_to_ft(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 3 * FRAME && !seen; n++) begin
      sample();
      if (last_ft) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    check(name, {20'd0, an, seg, dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
    check({name, "_ft"}, {31'd0, frame_tick}, 32'd0);
  endtask

  // Release reset (R = last low edge) and return the edge index of the first lit output.
  task automatic release_and_find_lit(output int first_lit, output logic [3:0] an_at, output logic [6:0] seg_at);
    first_lit = -1;
    an_at     = 4'hF;
    seg_at    = 7'h7F;
    reset_n   = 1'b1;
    for (int e = 1; e <= 3 * SC && first_lit < 0; e++) begin
      @(negedge clk);
      if (an != 4'hF) begin
        first_lit = e;
        an_at     = an;
        seg_at    = seg;
      end
    end
  endtask

  initial begin
    int first_lit;
    int first_ft;
    int e;
    logic [3:0] an_at;
    logic [6:0] seg_at;

    vecs[0] = '{16'h3210, 4'b0000, 4'b0000, 3'd7, {7'h30, 7'h24, 7'h79, 7'h40}, 32'h2A2A2A2A, 32'h00000000};
    vecs[1] = '{16'hABCD, 4'b0000, 4'b0000, 3'd7, {7'h08, 7'h03, 7'h46, 7'h21}, 32'h2A2A2A2A, 32'h00000000};
    vecs[2] = '{16'h7654, 4'b0000, 4'b0100, 3'd7, {7'h78, 7'h02, 7'h12, 7'h19}, 32'h2A002A2A, 32'h00000000};
    vecs[3] = '{16'h3210, 4'b0000, 4'b0000, 3'd3, {7'h30, 7'h24, 7'h79, 7'h40}, 32'h12121212, 32'h00000000};
    vecs[4] = '{16'h3210, 4'b0000, 4'b0000, 3'd0, {7'h30, 7'h24, 7'h79, 7'h40}, 32'h00000000, 32'h00000000};
    vecs[5] = '{16'h3210, 4'b0001, 4'b0000, 3'd7, {7'h30, 7'h24, 7'h79, 7'h40}, 32'h2A2A2A2A, 32'h0000002A};
    vecs[6] = '{16'hFE98, 4'b1010, 4'b0000, 3'd1, {7'h0E, 7'h06, 7'h10, 7'h00}, 32'h06060606, 32'h06000600};
    vecs[7] = '{16'h8888, 4'b1111, 4'b1111, 3'd7, {7'h00, 7'h00, 7'h00, 7'h00}, 32'h00000000, 32'h00000000};

    synced  = 1'b0;
    pos     = 0;
    last_ft = 1'b0;
    clear_stats();

    reset_n    = 1'b0;
    digits     = 16'h3210;
    dp_in      = 4'b0000;
    blank      = 4'b0000;
    brightness = 3'd7;
    hold       = 1'b0;
    set_exp(vecs[0].seg_codes);

    // Power-on reset and first-light / first-tick timing
    for (int i = 0; i < 3; i++) check_reset_outputs("por_dark");
    release_and_find_lit(first_lit, an_at, seg_at);
    check("por_first_lit_edge", first_lit, GC + 2);
    check("por_first_lit_an", {28'd0, an_at}, 32'h0000000E);
    check("por_first_lit_seg", {25'd0, seg_at}, 32'h00000040);
    first_ft = -1;
    e = first_lit;
    while (first_ft < 0 && e < 3 * FRAME) begin
      @(negedge clk);
      e++;
      if (frame_tick) first_ft = e;
    end
    check("por_first_ft_edge", first_ft, FRAME + 1);
    pos    = 0;
    synced = 1'b1;

    // Table: each row runs one settling frame, then seven frames of observation
    for (int r = 0; r < 8; r++) begin
      digits     = vecs[r].digits;
      dp_in      = vecs[r].dp_in;
      blank      = vecs[r].blank;
      brightness = vecs[r].bright;
      set_exp(vecs[r].seg_codes);
      run_to_ft($sformatf("row%0d_settle", r));
      clear_stats();
      run_samples(7 * FRAME);
      for (int i = 0; i < ND; i++) begin
        check($sformatf("row%0d_lit_d%0d", r, i), lit_cnt[i], {24'd0, vecs[r].lit[8*i +: 8]});
        check($sformatf("row%0d_dplow_d%0d", r, i), dpl_cnt[i], {24'd0, vecs[r].dpl[8*i +: 8]});
      end
      check($sformatf("row%0d_illegal", r), bad, 0);
      check($sformatf("row%0d_ticks", r), ft_cnt, 7);
    end

    // Snapshot: a mid-frame change stays invisible until the next frame
    digits     = 16'h3210;
    dp_in      = 4'b0000;
    blank      = 4'b0000;
    brightness = 3'd7;
    set_exp({7'h30, 7'h24, 7'h79, 7'h40});
    run_to_ft("snap_settle");
    clear_stats();
    run_samples(FRAME / 2);
    digits = 16'hABCD;
    run_samples(FRAME / 2);
    check("snap_old_shown", bad, 0);
    check("snap_old_tick", ft_cnt, 1);
    set_exp({7'h08, 7'h03, 7'h46, 7'h21});
    clear_stats();
    run_samples(FRAME);
    check("snap_new_shown", bad, 0);
    check("snap_new_lit_d0", lit_cnt[0], SC - GC);

    // Hold: snapshots suppressed for three frames
    clear_stats();
    run_samples(10);
    hold   = 1'b1;
    digits = 16'h1234;
    run_samples(FRAME - 10 + 3 * FRAME);
    check("hold_old_persists", bad, 0);
    check("hold_ticks", ft_cnt, 4);
    check("hold_lit_d3", lit_cnt[3], 4 * (SC - GC));

    // Hold released mid-frame: new value appears from the next frame
    clear_stats();
    run_samples(10);
    hold = 1'b0;
    run_samples(FRAME - 10);
    check("release_old_until_tick", bad, 0);
    set_exp({7'h79, 7'h24, 7'h30, 7'h19});
    clear_stats();
    run_samples(FRAME);
    check("release_new_shown", bad, 0);

    // Hold rising on the wrap edge itself suppresses that snapshot
    run_samples(FRAME - 1);
    hold   = 1'b1;
    digits = 16'h5A5A;
    clear_stats();
    run_samples(1 + FRAME);
    check("hold_on_wrap_suppressed", bad, 0);
    check("hold_on_wrap_lit_d2", lit_cnt[2], SC - GC);
    hold = 1'b0;

    // Reset asserted mid-slot while a digit is lit
    digits = 16'h3210;
    set_exp({7'h30, 7'h24, 7'h79, 7'h40});
    run_to_ft("midrst_settle");
    first_lit = -1;
    for (int n = 0; n < FRAME && first_lit < 0; n++) begin
      sample();
      if (an != 4'hF) first_lit = n;
    end
    check("midrst_found_lit", {31'd0, first_lit >= 0}, 32'd1);
    reset_n = 1'b0;
    synced  = 1'b0;
    for (int i = 0; i < 5; i++) check_reset_outputs($sformatf("midrst_dark%0d", i));
    release_and_find_lit(first_lit, an_at, seg_at);
    check("midrst_first_lit_edge", first_lit, GC + 2);
    check("midrst_first_lit_an", {28'd0, an_at}, 32'h0000000E);
    check("midrst_first_lit_seg", {25'd0, seg_at}, 32'h00000040);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised time-multiplexed seven-segment driver: scans NUM_DIGITS common-anode digits from one 10 MHz clock, with hex decode, per-digit decimal points and blanking, PWM brightness, an inter-digit ghosting guard, and tear-free frame-synchronous input snapshots. It sits between display-value producers (counters, FSMs, switch logic) and the board's an/seg/dp pins. It replaces the fixed 4-digit scanner. Every output is forced dark while reset is asserted.

## Interface
- NUM_DIGITS, 4: number of digits, 2..8.
- SCAN_COUNT, 5000: clocks per digit slot. The default gives a 2 kHz slot rate, which is a 500 Hz frame at 4 digits.
- GUARD_CYCLES, 16: dark clocks at the start of each slot. Requires GUARD_CYCLES + 1 < SCAN_COUNT.
- PWM_BITS, 3: brightness resolution.

- clk_10Mhz  in  1  system clock, all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- digits  in  4*NUM_DIGITS  hex value per digit. Digit i is bits [4i+3:4i]. Digit 0 is the rightmost digit and drives an[0].
- dp_in  in  NUM_DIGITS  1 = decimal point lit for digit i.
- blank  in  NUM_DIGITS  1 = digit i dark.
- brightness  in  PWM_BITS  0 = dark; all-ones = fully on.
- hold  in  1  1 = suppress frame snapshots.
- an  out  NUM_DIGITS  anodes, active-low, registered.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal-point cathode, active-low, registered.
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0, registered.

## Operation
- **Slot counter:** runs 0..SCAN_COUNT-1 and wraps.
- **Digit pointer:** advances at each slot terminal count, from NUM_DIGITS-1 back to 0. frame_tick=1 for the cycle after the wrap edge.
- **Shadow registers:** hold digits, dp_in, blank and brightness.
  - Loaded on the first clock after reset_n rises.
  - Reloaded on every pointer wrap to 0 when hold=0.
  - When hold=1, the shadows keep their old values.
  - Input changes between snapshots have no visible effect.
- **PWM counter:** free-running, counts 0..2^PWM_BITS-2 and wraps (period 2^PWM_BITS-1). pwm_on = (pwm_cnt < brightness_shadow).
- **Anode lit condition:** all of the following must hold:
  - slot counter >= GUARD_CYCLES;
  - blank_shadow[ptr] = 0;
  - pwm_on = 1.
- **When lit:**
  - an = ~(1<<ptr);
  - seg = hex decode of digit_shadow[ptr];
  - dp = ~dp_in_shadow[ptr].
- **When not lit:** an = all ones, seg = 7'h7F, dp = 1. Anodes and cathodes are never driven for a dark digit.
- **Decode:** standard hex 0-F, active-low. Examples: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, F = 7'b0001110.
- **Reset (reset_n=0 at a clock edge, including mid-slot or mid-frame):**
  - slot counter, pointer and pwm_cnt go to 0;
  - shadow blank goes to all ones;
  - outputs on that edge: an = all ones, seg = 7'h7F, dp = 1, frame_tick = 0.
  - All outputs stay at these values for as long as reset is held.

## Timing
- Outputs are registered: each output reflects internal state one clock later.
- For a slot starting at edge T (slot counter = 0), the outputs are dark for cycles T+1..T+GUARD_CYCLES. They are lit, subject to blank and PWM, from T+GUARD_CYCLES+1 through the first cycle of the next slot.
- After reset release at edge R:
  - the snapshot is taken at edge R+1;
  - digit 0 is first lit at edge R+GUARD_CYCLES+2.
- frame_tick period is NUM_DIGITS*SCAN_COUNT clocks. The first frame_tick after reset comes at edge R+NUM_DIGITS*SCAN_COUNT+1.
- A snapshot coinciding with hold rising is suppressed; hold is sampled on the wrap edge.
- Counter widths are $clog2 of the respective range. There is no overflow beyond the wrap points.

## Structure
- Shared package seven_seg_pkg holds:
  - SEG_BLANK = 7'h7F;
  - the active-low hex segment constants used by the decoder and the bench.
- One sub-module: the team's existing combinational seven_seg_decoder, instantiated once on the selected shadow digit.
- Everything else stays in this module: counters, pointer, shadows, PWM and output registers.

## Test plan
- **Reset:** NUM_DIGITS=4, SCAN_COUNT=8, GUARD_CYCLES=2, PWM_BITS=3. Assert reset_n=0 for 5 cycles mid-slot while a digit is lit.
  - Required: an=4'hF, seg=7'h7F, dp=1, frame_tick=0 at the first reset edge and throughout reset.
  - Required: after release, digit 0 is first lit 4 edges later.
- **Scan order:** same config, digits=16'h3210, brightness=7, blank=0.
  - Required: an cycles 1110, 1101, 1011, 0111, with seg = codes for 0, 1, 2, 3.
  - Required: each digit is lit 6 of 8 cycles; frame_tick pulses every 32 cycles.
- **Snapshot:** change digits to 16'hABCD mid-frame.
  - Required: old values are shown until frame_tick, new values from the next frame.
  - Repeat with hold=1: old values persist across 3 frames.
- **Blanking:** blank=4'b0100.
  - Required: an[2] is never 0; seg=7'h7F and dp=1 throughout slot 2; the other digits are unaffected.
- **PWM:** brightness=3.
  - Required: within the lit window, the active anode is low exactly 3 of every 7 consecutive cycles.
  - Required: brightness=0 keeps an = all ones permanently.
- **Decimal point:** dp_in=4'b0001.
  - Required: dp=0 only on cycles where an=4'b1110, otherwise 1.
